// File: rtl/spi_rd_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rd_datapath
//  Purpose  : SPI-master (mode 0) datapath for the serial-ROM reader. It
//             divides clk down to SCK, shifts the read address out on MOSI,
//             shifts words in from MISO, and writes each received word into
//             the local ROM buffer. It also returns the status flags that the
//             controller branches on.
//  Options  : SPI_MISO_SYNC_EN - 2-flop MISO synchroniser (needs DIV >= 3)
//  Revision : 1.0 - initial release
// ============================================================================
module spi_rd_datapath #(
  parameter int DIV     = 2,
  parameter int WORD_W  = 8,
  parameter int CS_HOLD = 4,
  parameter int ROM_AW  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck_en,
  input  logic              rstSCK,
  input  logic              write_addr_en,
  input  logic              en_cnt_sck,
  input  logic              cnt_en,
  input  logic              addr_cnt_en,
  input  logic              en,
  input  logic              write_word_to_rom,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic              cs_n,
  output logic              cnt_sck_done,
  output logic              miso_zero,
  output logic              cnt_done,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata
);

  localparam int c_div_w  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_cnt_w  = $clog2(WORD_W + 1);
  localparam int c_hold_w = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

  localparam logic [c_div_w-1:0]  c_div_last   = c_div_w'(DIV - 1);
  localparam logic [c_cnt_w-1:0]  c_sck_pulses = c_cnt_w'(WORD_W);
  localparam logic [c_hold_w-1:0] c_hold_last  = c_hold_w'(CS_HOLD - 1);

  logic [c_div_w-1:0]  div_cnt_q,  div_cnt_d;
  logic                sck_q,      sck_d;
  logic [WORD_W-1:0]   tx_sh_q,    tx_sh_d;
  logic [WORD_W-1:0]   rx_sh_q,    rx_sh_d;
  logic [c_cnt_w-1:0]  sck_cnt_q,  sck_cnt_d;
  logic [c_hold_w-1:0] hold_cnt_q, hold_cnt_d;
  logic [WORD_W-1:0]   rd_addr_q,  rd_addr_d;
  logic [ROM_AW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic                cs_n_q,     cs_n_d;
  logic                rom_we_q,   rom_we_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [WORD_W-1:0]   rom_wdata_q, rom_wdata_d;

  logic w_toggle;
  logic w_rise;
  logic w_fall;
  logic w_miso_s;

`ifdef SPI_MISO_SYNC_EN
  logic miso_meta_q, miso_meta_d;
  logic miso_sync_q, miso_sync_d;

  // Two-stage synchroniser feeding the RX shifter.
  always_comb begin
    miso_meta_d = miso;
    miso_sync_d = miso_meta_q;
  end

  // Synchroniser registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= miso_meta_d;
      miso_sync_q <= miso_sync_d;
    end
  end

  assign w_miso_s = miso_sync_q;
`else
  assign w_miso_s = miso;
`endif

  // SCK divider: rstSCK wins over sck_en; sck toggles when the count wraps.
  always_comb begin
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    w_toggle  = 1'b0;
    if (rstSCK) begin
      div_cnt_d = '0;
      sck_d     = 1'b0;
    end else if (sck_en) begin
      if (div_cnt_q == c_div_last) begin
        div_cnt_d = '0;
        sck_d     = ~sck_q;
        w_toggle  = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + c_div_w'(1);
      end
    end
  end

  assign w_rise = w_toggle & ~sck_q;
  assign w_fall = w_toggle &  sck_q;

  // Shifters and SCK pulse counter: a load beats a shift, a clear beats a count.
  always_comb begin
    tx_sh_d = tx_sh_q;
    if (write_addr_en) begin
      tx_sh_d = rd_addr_q;
    end else if (w_fall) begin
      tx_sh_d = {tx_sh_q[WORD_W-2:0], 1'b0};
    end

    rx_sh_d = rx_sh_q;
    if (w_rise) begin
      rx_sh_d = {rx_sh_q[WORD_W-2:0], w_miso_s};
    end

    sck_cnt_d = sck_cnt_q;
    if (!en_cnt_sck) begin
      sck_cnt_d = '0;
    end else if (w_fall && (sck_cnt_q != c_sck_pulses)) begin
      sck_cnt_d = sck_cnt_q + c_cnt_w'(1);
    end
  end

  // ROM write port, read address, chip select and CS hold counter.
  always_comb begin
    rom_we_d    = write_word_to_rom;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    wr_ptr_d    = wr_ptr_q;
    if (write_word_to_rom) begin
      rom_addr_d  = wr_ptr_q;
      rom_wdata_d = rx_sh_q;
      wr_ptr_d    = wr_ptr_q + ROM_AW'(1);
    end

    rd_addr_d = rd_addr_q;
    if (addr_cnt_en) begin
      rd_addr_d = rd_addr_q + WORD_W'(1);
    end

    cs_n_d = en;

    hold_cnt_d = hold_cnt_q;
    if (!cnt_en) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != c_hold_last) begin
      hold_cnt_d = hold_cnt_q + c_hold_w'(1);
    end
  end

  // State registers; reset returns everything to idle and cancels any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      sck_q       <= 1'b0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      sck_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rd_addr_q   <= '0;
      wr_ptr_q    <= '0;
      cs_n_q      <= 1'b1;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      sck_q       <= sck_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      sck_cnt_q   <= sck_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rd_addr_q   <= rd_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      cs_n_q      <= cs_n_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
    end
  end

  assign sck          = sck_q;
  assign mosi         = tx_sh_q[WORD_W-1];
  assign cs_n         = cs_n_q;
  assign cnt_sck_done = (sck_cnt_q == c_sck_pulses);
  assign miso_zero    = (rx_sh_q == '0);
  assign cnt_done     = (hold_cnt_q == c_hold_last);
  assign rom_we       = rom_we_q;
  assign rom_addr     = rom_addr_q;
  assign rom_wdata    = rom_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_rd_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_rd_datapath
//  Purpose  : Self-checking bench for spi_rd_datapath: directed scenarios with
//             literal expectations plus randomized control traffic compared
//             every cycle against a queue-based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_rd_datapath;

  localparam int DIV     = 2;
  localparam int WORD_W  = 8;
  localparam int CS_HOLD = 4;
  localparam int ROM_AW  = 6;
  localparam int WMASK   = (1 << WORD_W) - 1;
  localparam int PMASK   = (1 << ROM_AW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sck_en = 1'b0, rstSCK = 1'b0, write_addr_en = 1'b0;
  logic              en_cnt_sck = 1'b0, cnt_en = 1'b0, addr_cnt_en = 1'b0;
  logic              en = 1'b0, write_word_to_rom = 1'b0, miso = 1'b0;
  logic              sck, mosi, cs_n, cnt_sck_done, miso_zero, cnt_done, rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [WORD_W-1:0] rom_wdata;

  always #5 clk = ~clk;

  spi_rd_datapath #(
    .DIV(DIV), .WORD_W(WORD_W), .CS_HOLD(CS_HOLD), .ROM_AW(ROM_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sck_en(sck_en), .rstSCK(rstSCK),
    .write_addr_en(write_addr_en), .en_cnt_sck(en_cnt_sck), .cnt_en(cnt_en),
    .addr_cnt_en(addr_cnt_en), .en(en), .write_word_to_rom(write_word_to_rom),
    .miso(miso), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .cnt_sck_done(cnt_sck_done), .miso_zero(miso_zero), .cnt_done(cnt_done),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  int m_phase;      // clk cycles spent in the current SCK half-period
  bit m_sck;
  bit m_txq[$];     // address bits still to be presented on MOSI, MSB first
  int m_rx;
  int m_pulses;
  int m_hold;
  int m_rd;
  int m_ptr;
  bit m_cs;
  bit m_we;
  int m_waddr;
  int m_wdata;
  bit m_s1, m_s2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_sck = 0; m_txq.delete(); m_rx = 0; m_pulses = 0;
    m_hold = 0; m_rd = 0; m_ptr = 0; m_cs = 1; m_we = 0; m_waddr = 0;
    m_wdata = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_step();
    bit ms, rise, fall;
    int old_rd, old_rx, old_ptr;
    old_rd  = m_rd;
    old_rx  = m_rx;
    old_ptr = m_ptr;
`ifdef SPI_MISO_SYNC_EN
    ms = m_s2; m_s2 = m_s1; m_s1 = miso;
`else
    ms = miso;
`endif
    rise = 0; fall = 0;
    if (rstSCK) begin
      m_phase = 0; m_sck = 0;
    end else if (sck_en) begin
      m_phase = m_phase + 1;
      if (m_phase == DIV) begin
        m_phase = 0;
        rise = !m_sck;
        fall = m_sck;
        m_sck = !m_sck;
      end
    end
    if (write_addr_en) begin
      m_txq.delete();
      for (int k = WORD_W - 1; k >= 0; k--) m_txq.push_back(bit'((old_rd >> k) & 1));
    end else if (fall && m_txq.size() > 0) begin
      void'(m_txq.pop_front());
    end
    if (rise) m_rx = ((m_rx << 1) | int'(ms)) & WMASK;
    if (!en_cnt_sck) m_pulses = 0;
    else if (fall && m_pulses < WORD_W) m_pulses = m_pulses + 1;
    m_we = write_word_to_rom;
    if (write_word_to_rom) begin
      m_waddr = old_ptr;
      m_wdata = old_rx;
      m_ptr   = (old_ptr + 1) & PMASK;
    end
    if (addr_cnt_en) m_rd = (m_rd + 1) & WMASK;
    m_cs = en;
    if (!cnt_en) m_hold = 0;
    else if (m_hold < CS_HOLD - 1) m_hold = m_hold + 1;
  endtask

  // Cycle compare of all meaningful outputs against the model.
  task automatic compare();
    bit exp_mosi;
    bit exp_done;
    exp_mosi = (m_txq.size() > 0) ? m_txq[0] : 1'b0;
    exp_done = (m_pulses == WORD_W);
    check("cyc_sck", 32'(sck), 32'(m_sck));
    check("cyc_mosi", 32'(mosi), 32'(exp_mosi));
    check("cyc_cs_n", 32'(cs_n), 32'(m_cs));
    check("cyc_cnt_sck_done", 32'(cnt_sck_done), 32'(exp_done));
    check("cyc_cnt_done", 32'(cnt_done), 32'(m_hold == CS_HOLD - 1));
    check("cyc_rom_we", 32'(rom_we), 32'(m_we));
    if (m_we) begin
      check("cyc_rom_addr", 32'(rom_addr), 32'(m_waddr));
      check("cyc_rom_wdata", 32'(rom_wdata), 32'(m_wdata));
    end
    if (exp_done) check("cyc_miso_zero", 32'(miso_zero), 32'(m_rx == 0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin : main
    logic [7:0] rx_pat;
    logic [7:0] mosi_bits;
    int         nrise;
    bit         prev_sck;

    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_rom_we", 32'(rom_we), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_rom_wdata", 32'(rom_wdata), 32'd0);
    check("rst_cnt_sck_done", 32'(cnt_sck_done), 32'd0);
    check("rst_cnt_done", 32'(cnt_done), 32'd0);
    check("rst_miso_zero", 32'(miso_zero), 32'd1);
    rst_n = 1'b1;

    // Bring the read address to 0xA5
    addr_cnt_en = 1'b1;
    repeat (8'hA5) tick();
    addr_cnt_en = 1'b0;
    check("rd_addr_a5", 32'(dut.rd_addr_q), 32'hA5);

    // Address shift-out with 0x3C shifted in simultaneously
    write_addr_en = 1'b1;
    tick();
    write_addr_en = 1'b0;
    check("mosi_first_bit", 32'(mosi), 32'd1);
    rx_pat = 8'h3C;
    mosi_bits = 8'h00;
    nrise = 0;
    prev_sck = 1'b0;
    miso = rx_pat[7];
    en_cnt_sck = 1'b1;
    sck_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (sck && !prev_sck) begin
        mosi_bits = {mosi_bits[6:0], mosi};
        nrise++;
        if (nrise < 8) miso = rx_pat[7 - nrise];
      end
      prev_sck = sck;
      if (i == 31) check("sck_done_at_31", 32'(cnt_sck_done), 32'd0);
    end
    sck_en = 1'b0;
    check("sck_done_at_32", 32'(cnt_sck_done), 32'd1);
    check("sck_low_at_done", 32'(sck), 32'd0);
    check("rise_count", 32'(nrise), 32'd8);
    check("mosi_bits_a5", 32'(mosi_bits), 32'hA5);
    check("rx_3c", 32'(dut.rx_sh_q), 32'h3C);
    check("miso_zero_3c", 32'(miso_zero), 32'd0);

    // ROM write of the received word
    write_word_to_rom = 1'b1;
    tick();
    write_word_to_rom = 1'b0;
    check("wr0_we", 32'(rom_we), 32'd1);
    check("wr0_addr", 32'(rom_addr), 32'd0);
    check("wr0_data", 32'(rom_wdata), 32'h3C);
    tick();
    check("wr0_we_single", 32'(rom_we), 32'd0);
    write_word_to_rom = 1'b1;
    tick();
    write_word_to_rom = 1'b0;
    check("wr1_addr", 32'(rom_addr), 32'd1);

    // Zero word
    en_cnt_sck = 1'b0;
    miso = 1'b0;
    tick();
    en_cnt_sck = 1'b1;
    sck_en = 1'b1;
    repeat (32) tick();
    sck_en = 1'b0;
    check("zero_done", 32'(cnt_sck_done), 32'd1);
    check("zero_miso_zero", 32'(miso_zero), 32'd1);

    // CS hold
    en = 1'b0;
    tick();
    check("cs_low", 32'(cs_n), 32'd0);
    en = 1'b1;
    cnt_en = 1'b1;
    tick();
    check("cs_high_1clk", 32'(cs_n), 32'd1);
    check("hold_1", 32'(cnt_done), 32'd0);
    tick();
    check("hold_2", 32'(cnt_done), 32'd0);
    tick();
    check("hold_3", 32'(cnt_done), 32'd1);
    cnt_en = 1'b0;

    // Address wrap 0xFF -> 0x00
    addr_cnt_en = 1'b1;
    repeat (8'hFF - 8'hA5) tick();
    addr_cnt_en = 1'b0;
    check("rd_addr_ff", 32'(dut.rd_addr_q), 32'hFF);
    addr_cnt_en = 1'b1;
    tick();
    addr_cnt_en = 1'b0;
    check("rd_addr_wrap", 32'(dut.rd_addr_q), 32'h00);

    // Write pointer wrap (two writes done already)
    write_word_to_rom = 1'b1;
    repeat (62) tick();
    write_word_to_rom = 1'b0;
    check("ptr_last", 32'(rom_addr), 32'd63);
    write_word_to_rom = 1'b1;
    tick();
    write_word_to_rom = 1'b0;
    check("ptr_wrap_addr", 32'(rom_addr), 32'd0);
    check("ptr_wrap_we", 32'(rom_we), 32'd1);

    // Counter clear coinciding with a fall event
    en_cnt_sck = 1'b0;
    tick();
    en_cnt_sck = 1'b1;
    sck_en = 1'b1;
    repeat (7) tick();
    check("clr_pre_cnt", 32'(dut.sck_cnt_q), 32'd1);
    check("clr_pre_sck", 32'(sck), 32'd1);
    en_cnt_sck = 1'b0;
    tick();
    check("clr_cnt", 32'(dut.sck_cnt_q), 32'd0);
    check("clr_sck_fell", 32'(sck), 32'd0);
    sck_en = 1'b0;

    // Randomized control traffic with a mid-phase asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      sck_en            = ($urandom_range(99) < 80);
      rstSCK            = ($urandom_range(99) < 3);
      write_addr_en     = ($urandom_range(99) < 5);
      en_cnt_sck        = ($urandom_range(99) < 92);
      cnt_en            = ($urandom_range(99) < 70);
      addr_cnt_en       = ($urandom_range(99) < 10);
      en                = ($urandom_range(99) < 50);
      write_word_to_rom = ($urandom_range(99) < 10);
      miso              = ($urandom_range(1) == 1);
      if (i == 1500) begin
        write_word_to_rom = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cs_n", 32'(cs_n), 32'd1);
        check("async_rst_sck", 32'(sck), 32'd0);
        check("async_rst_rom_we", 32'(rom_we), 32'd0);
        check("async_rst_rd_addr", 32'(dut.rd_addr_q), 32'd0);
        model_reset();
        @(negedge clk);
        check("async_rst_no_write", 32'(rom_we), 32'd0);
        rst_n = 1'b1;
        compare();
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
